// File: rtl/gf180mcu_fd_sc_mcu7t5v0__cell2_bist.sv
// BIST controller for a two-input, one-output standard cell (A1, A2 -> Z).
// Sweeps {A1,A2} = 00,01,10,11 for PASSES passes. Each vector is held for SETTLE cycles
// before Z is sampled. Mismatches against the FUNC truth table are counted with saturation,
// and the first failing vector is captured.
module gf180mcu_fd_sc_mcu7t5v0__cell2_bist #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 4,
  parameter int unsigned FUNC   = 0,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             Z,
  output logic             A1,
  output logic             A2,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [1:0]       FAIL_VEC,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [1:0] Func     = FUNC[1:0];
  localparam logic [7:0] LastCnt  = 8'(SETTLE - 1);
  localparam logic [7:0] LastPass = 8'(PASSES - 1);

  // Supplies are pass-through pins for the test structure; no logic depends on them.
  wire unused_supply = VDD ^ VSS;

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       pass_q, pass_d;
  logic [1:0]       vec_q, vec_d;
  logic             a1_q, a1_d, a2_q, a2_d;
  logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fvec_q, fvec_d;

  logic             exp_z;
  logic             mismatch;
  logic             last_vec;
  logic [1:0]       vec_nxt;

  // Expected cell output for the vector currently driven.
  always_comb begin
    exp_z = 1'b0;
    case (Func)
      2'd0:    exp_z = &vec_q;
      2'd1:    exp_z = ~&vec_q;
      2'd2:    exp_z = |vec_q;
      default: exp_z = ~|vec_q;
    endcase
  end

  // Case-inequality so an X or Z on the cell output counts as a failure.
  assign mismatch = (Z !== exp_z);
  assign last_vec = (vec_q == 2'b11) && (pass_q == LastPass);
  assign vec_nxt  = vec_q + 2'd1;

  // Next-state logic for the sequencer and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    case (state_q)
      StIdle, StDone: begin
        if (START) begin
          err_d   = '0;
          fvec_d  = 2'b00;
          fail_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 8'd0;
          vec_d   = 2'b00;
          a1_d    = 1'b0;
          a2_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LastCnt) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (mismatch) begin
          if (!(&err_q)) begin
            err_d = err_q + 1'b1;
          end
          if (err_q == '0) begin
            fvec_d = vec_q;
          end
        end
        if (last_vec) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          fail_d  = mismatch || (err_q != '0);
          a1_d    = 1'b0;
          a2_d    = 1'b0;
        end else begin
          vec_d   = vec_nxt;
          a1_d    = vec_nxt[1];
          a2_d    = vec_nxt[0];
          cnt_d   = 8'd0;
          state_d = StSettle;
          if (vec_q == 2'b11) begin
            pass_d = pass_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers, cleared asynchronously by RN.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      pass_q  <= 8'd0;
      vec_q   <= 2'b00;
      a1_q    <= 1'b0;
      a2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
    end
  end

  assign A1       = a1_q;
  assign A2       = a2_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign FAIL     = fail_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fvec_q;

endmodule
